// File: rtl/imm_extend_pkg.sv
// Shared types and the immediate-extension function for the imm_extend_pipe stage.
// Widths are passed per call so one function serves every parameterisation.
package imm_extend_pkg;

  localparam int unsigned ExtMaxW  = 64;
  localparam int unsigned ExtInW   = 16;
  localparam int unsigned ExtOutW  = 32;

  typedef enum logic [1:0] {
    EXT_SEXT  = 2'b00,
    EXT_ZEXT  = 2'b01,
    EXT_UPPER = 2'b10,
    EXT_BROFF = 2'b11
  } ext_mode_t;

  // imm is right-aligned; bits at or above in_w are ignored. Result is masked to out_w bits.
  function automatic logic [ExtMaxW-1:0] ext_apply(
    input logic [ExtMaxW-1:0] imm,
    input ext_mode_t          mode,
    input int unsigned        in_w  = ExtInW,
    input int unsigned        out_w = ExtOutW
  );
    logic [ExtMaxW-1:0] mask_in;
    logic [ExtMaxW-1:0] mask_out;
    logic [ExtMaxW-1:0] imm_m;
    logic [ExtMaxW-1:0] sext;
    logic [ExtMaxW-1:0] res;
    logic               sign;

    mask_in  = {ExtMaxW{1'b1}} >> (ExtMaxW - in_w);
    mask_out = {ExtMaxW{1'b1}} >> (ExtMaxW - out_w);
    imm_m    = imm & mask_in;
    sign     = |(imm_m >> (in_w - 1));
    sext     = sign ? (imm_m | ~mask_in) : imm_m;
    res      = '0;

    unique case (mode)
      EXT_SEXT:  res = sext;
      EXT_ZEXT:  res = imm_m;
      EXT_UPPER: res = imm_m << in_w;
      EXT_BROFF: res = sext << 2;
    endcase

    return res & mask_out;
  endfunction

endpackage

// File: rtl/ext_skid_buf.sv
// Generic valid/ready register slice. IMM_EXTEND_SKID_EN selects a two-entry skid buffer with a
// registered ready; otherwise a single output register with ready derived from ready_i.
module ext_skid_buf #(
  parameter int unsigned DATA_W = 37
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o
);

`ifdef IMM_EXTEND_SKID_EN

  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              rdy_q;
  logic              push, pop;

  assign push = valid_i && rdy_q;
  assign pop  = main_valid_q && ready_i;

  // Skid always holds the younger beat; it refills main before any new input is taken.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (pop) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (push) begin
      if (!main_valid_q || pop) begin
        main_valid_d = 1'b1;
        main_data_d  = data_i;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = data_i;
      end
    end else if (pop) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
      rdy_q        <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
      rdy_q        <= !skid_valid_d;
    end
  end

  assign ready_o = rdy_q;
  assign valid_o = main_valid_q;
  assign data_o  = main_data_q;

`else

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign ready_o = !valid_q || ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (valid_i && ready_o) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

`endif

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate-extension stage with valid/ready flow control and flush.
// Define IMM_EXTEND_SKID_EN for a two-entry skid buffer with registered in_ready.
module imm_extend_pipe
  import imm_extend_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned DataW = OUT_W + TAG_W;

  if (IN_W < 2 || IN_W >= OUT_W || OUT_W < 2 * IN_W || OUT_W >= ExtMaxW) begin : g_param_check
    $error("imm_extend_pipe: illegal IN_W/OUT_W combination");
  end

  logic [ExtMaxW-1:0] ext_full;
  logic [OUT_W-1:0]   ext_data;
  logic               buf_ready;
  logic               buf_push;
  logic [DataW-1:0]   buf_din;
  logic [DataW-1:0]   buf_dout;
  logic               unused_ext_hi;

  always_comb begin
    ext_full = ext_apply(ExtMaxW'(in_imm), ext_mode_t'(in_mode), IN_W, OUT_W);
  end

  assign ext_data      = ext_full[OUT_W-1:0];
  assign unused_ext_hi = ^ext_full[ExtMaxW-1:OUT_W];

  // Reset and flush both block acceptance in the same cycle they are asserted.
  assign in_ready = rst_n && !flush && buf_ready;
  assign buf_push = in_valid && in_ready;
  assign buf_din  = {in_tag, ext_data};

  ext_skid_buf #(
    .DATA_W (DataW)
  ) u_buf (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .valid_i (buf_push),
    .ready_o (buf_ready),
    .data_i  (buf_din),
    .valid_o (out_valid),
    .ready_i (out_ready),
    .data_o  (buf_dout)
  );

  assign out_data = buf_dout[OUT_W-1:0];
  assign out_tag  = buf_dout[DataW-1:OUT_W];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed self-checking bench for imm_extend_pipe (default 16->32 and an 8->16 instance).
module tb_imm_extend_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag, out_tag;
  logic [31:0] out_data;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0]  b_in_imm;
  logic [1:0]  b_in_mode;
  logic [4:0]  b_in_tag, b_out_tag;
  logic [15:0] b_out_data;

  int errors = 0;
  int checks = 0;

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  imm_extend_pipe #(.IN_W(8), .OUT_W(16), .TAG_W(5)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (b_flush),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_imm    (b_in_imm),
    .in_mode   (b_in_mode),
    .in_tag    (b_in_tag),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .out_tag   (b_out_tag)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow a further settle delay.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   occ, sent, got, cyc;
    logic exp_rdy, exp_valid, prev_stall;
    logic [31:0] prev_data;
    logic [3:0]  pat;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_imm = '0; in_mode = 2'b00; in_tag = '0;
    out_ready = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_imm = '0; b_in_mode = 2'b00; b_in_tag = '0;
    b_out_ready = 1'b1;

    // Reset state
    tick(); tick(); settle();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    tick(); settle();
    chk("post_rst_in_ready", in_ready, 1);

    // Mode vectors back to back
    in_valid = 1'b1; in_mode = 2'b00; in_imm = 16'h8001; in_tag = 5'd3; out_ready = 1'b1;
    tick();
    in_mode = 2'b01; in_imm = 16'h8001; in_tag = 5'd4; settle();
    chk("sext_valid", out_valid, 1);
    chk("sext_data", out_data, 32'hFFFF8001);
    chk("sext_tag", out_tag, 3);
    tick();
    in_mode = 2'b10; in_imm = 16'h1234; in_tag = 5'd5; settle();
    chk("zext_data", out_data, 32'h00008001);
    chk("zext_tag", out_tag, 4);
    tick();
    in_mode = 2'b11; in_imm = 16'hFFFF; in_tag = 5'd6; settle();
    chk("upper_data", out_data, 32'h12340000);
    tick();
    in_mode = 2'b11; in_imm = 16'h4000; in_tag = 5'd7; settle();
    chk("broff_neg_data", out_data, 32'hFFFFFFFC);
    chk("broff_neg_tag", out_tag, 6);
    tick();
    in_valid = 1'b0; settle();
    chk("broff_pos_data", out_data, 32'h00010000);
    chk("broff_pos_valid", out_valid, 1);
    tick(); settle();
    chk("drained_valid", out_valid, 0);

    // Backpressure stream 1..8 with out_ready pattern 1,0,0,1
    pat = 4'b1001;
    occ = 0; sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0;
    in_mode = 2'b00;
    while (got < 8 && cyc < 60) begin
      in_valid  = (sent < 8);
      in_imm    = 16'(sent + 1);
      in_tag    = 5'(sent + 1);
      out_ready = pat[cyc % 4];
      settle();
`ifdef IMM_EXTEND_SKID_EN
      exp_rdy = (occ < 2);
`else
      exp_rdy = (occ == 0) || out_ready;
`endif
      exp_valid = (occ > 0);
      chk("bp_in_ready", in_ready, exp_rdy);
      chk("bp_out_valid", out_valid, exp_valid);
      if (prev_stall) chk("bp_stall_hold", out_data, prev_data);
      if (exp_valid && out_ready) begin
        chk("bp_order", out_data, 32'(got + 1));
        got++;
        occ--;
      end
      if (in_valid && exp_rdy) begin
        sent++;
        occ++;
      end
      prev_stall = exp_valid && !out_ready;
      prev_data  = out_data;
      cyc++;
      tick();
    end
    chk("bp_count", got, 8);
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); settle();
    chk("bp_empty", out_valid, 0);

    // Flush while full, with an input offered in the flush cycle
    in_valid = 1'b1; in_mode = 2'b01; in_imm = 16'h0011; in_tag = 5'd11; out_ready = 1'b0;
    tick();
    in_imm = 16'h0022; in_tag = 5'd12;
    tick(); settle();
    chk("full_in_ready", in_ready, 0);
    chk("full_hold_data", out_data, 32'h00000011);
    flush = 1'b1; in_imm = 16'h0033; in_tag = 5'd13; settle();
    chk("flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0; settle();
    chk("flush_out_valid", out_valid, 0);
    chk("flush_stale_data", out_data, 32'h00000011);
    in_valid = 1'b1; in_mode = 2'b00; in_imm = 16'h0044; in_tag = 5'd14; out_ready = 1'b1;
    settle();
    chk("post_flush_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0; settle();
    chk("post_flush_valid", out_valid, 1);
    chk("post_flush_data", out_data, 32'h00000044);
    chk("post_flush_tag", out_tag, 14);
    tick(); settle();
    chk("post_flush_drop", out_valid, 0);

    // Reset mid-stream
    in_valid = 1'b1; in_mode = 2'b01; in_imm = 16'h0055; in_tag = 5'd21; out_ready = 1'b0;
    tick();
    in_valid = 1'b0; settle();
    chk("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0; settle();
    chk("rst_low_in_ready", in_ready, 0);
    tick(); settle();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_tag", out_tag, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    tick(); settle();
    chk("rel_in_ready", in_ready, 1);
    in_valid = 1'b1; in_mode = 2'b01; in_imm = 16'h00FF; in_tag = 5'd9; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; settle();
    chk("rel_beat_valid", out_valid, 1);
    chk("rel_beat_data", out_data, 32'h000000FF);
    chk("rel_beat_tag", out_tag, 9);

    // 8 -> 16 instance
    b_in_valid = 1'b1; b_in_mode = 2'b00; b_in_imm = 8'h80; b_in_tag = 5'd1; settle();
    chk("b_in_ready", b_in_ready, 1);
    tick();
    b_in_mode = 2'b10; b_in_imm = 8'hAB; b_in_tag = 5'd2; settle();
    chk("b_sext_data", b_out_data, 16'hFF80);
    chk("b_sext_tag", b_out_tag, 1);
    tick();
    b_in_mode = 2'b11; b_in_imm = 8'hFF; b_in_tag = 5'd3; settle();
    chk("b_upper_data", b_out_data, 16'hAB00);
    tick();
    b_in_valid = 1'b0; settle();
    chk("b_broff_data", b_out_data, 16'hFFFC);
    chk("b_broff_valid", b_out_valid, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
